soc_onchip_ram_burst: RTL and testbench

- Parametrised single-clock on-chip RAM with an Avalon-MM slave port. Successor to the fixed-size dual-port on-chip memory in the soc_system fabric.
- Adds burst reads and writes (burstcount), a readdatavalid pipeline, selectable read latency, address wrap-around and a sticky protocol-error flag.
- Sits behind the HPS/ACP interconnect as a streaming buffer target.

---
 rtl/soc_onchip_ram_burst_pkg.sv | 24 ++
 rtl/soc_onchip_ram_burst_if.sv | 27 ++
 rtl/soc_onchip_ram_burst_array.sv | 60 ++++++
 rtl/soc_onchip_ram_burst.sv | 206 ++++++++++++++++++++
 tb/tb_soc_onchip_ram_burst.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_onchip_ram_burst_pkg.sv
// Shared types and elaboration helpers for the burst-capable on-chip RAM.
package soc_onchip_ram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

  // Ceiling log2, used to check that DEPTH fits the address width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/soc_onchip_ram_burst_if.sv
// Avalon-MM slave bus bundle between a fabric master and the RAM.
interface soc_onchip_ram_burst_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 10,
  parameter int BURST_W = 4
);
  logic                  chipselect;
  logic [ADDR_W-1:0]     address;
  logic [BURST_W-1:0]    burstcount;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output chipselect, address, burstcount, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, address, burstcount, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/soc_onchip_ram_burst_array.sv
// Simple dual-port RAM: byte-enabled write port, registered read with optional output register.
module soc_onchip_ram_array #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int OUTREG = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  input  logic                oce_i,
  output logic [DATA_W-1:0]   rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Byte-lane write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // First read stage; holds its value between read issues.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q <= {DATA_W{1'b0}};
    end else if (en_i && re_i) begin
      rd_q <= mem_q[raddr_i];
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [DATA_W-1:0] out_q;
    // Output register advances only when a valid word sits in the first stage.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        out_q <= {DATA_W{1'b0}};
      end else if (oce_i) begin
        out_q <= rd_q;
      end
    end
    assign rdata_o = out_q;
  end else begin : g_noreg
    logic unused_oce_s;
    assign unused_oce_s = oce_i;
    assign rdata_o      = rd_q;
  end

endmodule

// File: rtl/soc_onchip_ram_burst.sv
// Avalon-MM burst RAM: FSM, burst counter, address generator and read-valid pipeline.
module soc_onchip_ram_burst
  import soc_onchip_ram_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int BURST_W = 4,
  parameter int OUTREG  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  soc_onchip_ram_burst_if.slave bus,
  output logic                  protocol_err
);
  localparam int                 MAX_BEATS = 2 ** (BURST_W - 1);
  localparam logic [BURST_W-1:0] MAX_BC    = BURST_W'(MAX_BEATS);
  localparam logic [BURST_W-1:0] ONE_BC    = BURST_W'(1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  if ((DATA_W % 8) != 0 || DEPTH < 2 || clog2(DEPTH) > ADDR_W || BURST_W < 2) begin : g_bad_params
    $error("soc_onchip_ram_burst: illegal parameter combination");
  end

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic               err_q, err_d;
  logic               vld0_q;
  logic               vld_out_s;
  logic               wait_s, we_s, re_s, start_s;
  logic [ADDR_W-1:0]  waddr_s, raddr_s;
  logic [BURST_W-1:0] beats_s;
  logic               bc_bad_s;

  function automatic logic [ADDR_W-1:0] incr_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? {ADDR_W{1'b0}} : a + ADDR_W'(1);
  endfunction

  // Clamp the requested burst length: zero becomes one beat, oversize becomes the maximum.
  always_comb begin
    beats_s  = bus.burstcount;
    bc_bad_s = 1'b0;
    if (bus.burstcount == {BURST_W{1'b0}}) begin
      beats_s  = ONE_BC;
      bc_bad_s = 1'b1;
    end else if (bus.burstcount > MAX_BC) begin
      beats_s  = MAX_BC;
      bc_bad_s = 1'b1;
    end else begin
      beats_s  = bus.burstcount;
      bc_bad_s = 1'b0;
    end
  end

  // FSM outputs: stall, command start and the RAM port controls.
  always_comb begin
    wait_s  = 1'b1;
    start_s = 1'b0;
    we_s    = 1'b0;
    re_s    = 1'b0;
    waddr_s = addr_q;
    raddr_s = addr_q;
    if (!clken) begin
      wait_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          wait_s  = 1'b0;
          start_s = bus.chipselect & (bus.read | bus.write);
          we_s    = bus.chipselect & bus.write & ~reset;
          re_s    = bus.chipselect & bus.read & ~bus.write & ~reset;
          waddr_s = bus.address;
          raddr_s = bus.address;
        end
        WR_BURST: begin
          wait_s = ~bus.write;
          we_s   = bus.chipselect & bus.write & ~reset;
        end
        RD_BURST: begin
          wait_s = 1'b1;
          re_s   = ~reset;
        end
        default: begin
          wait_s = 1'b1;
        end
      endcase
    end
  end

  // Next state, burst address/counter and sticky error.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    err_d    = err_q;
    if (!clken) begin
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            if (bc_bad_s || (bus.read && bus.write)) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (beats_s > ONE_BC) begin
              addr_d   = incr_addr(bus.address);
              remain_d = beats_s - ONE_BC;
              state_d  = bus.write ? WR_BURST : RD_BURST;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WR_BURST: begin
          if (bus.chipselect && bus.write) begin
            addr_d   = incr_addr(addr_q);
            remain_d = remain_q - ONE_BC;
            state_d  = (remain_q == ONE_BC) ? IDLE : WR_BURST;
          end else if (bus.chipselect && bus.read) begin
            err_d = 1'b1;
          end else begin
            state_d = WR_BURST;
          end
        end
        RD_BURST: begin
          addr_d   = incr_addr(addr_q);
          remain_d = remain_q - ONE_BC;
          state_d  = (remain_q == ONE_BC) ? IDLE : RD_BURST;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, address, counter and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      remain_q <= {BURST_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  // First valid stage follows each address issued to the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld0_q <= 1'b0;
    end else if (clken) begin
      vld0_q <= re_s;
    end
  end

  if (OUTREG != 0) begin : g_lat2
    logic vld1_q;
    // Second valid stage tracks the RAM output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld1_q <= 1'b0;
      end else if (clken) begin
        vld1_q <= vld0_q;
      end
    end
    assign vld_out_s = vld1_q;
  end else begin : g_lat1
    assign vld_out_s = vld0_q;
  end

  soc_onchip_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .OUTREG (OUTREG)
  ) u_array (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (clken),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (bus.writedata),
    .be_i    (bus.byteenable),
    .re_i    (re_s),
    .raddr_i (raddr_s),
    .oce_i   (clken & vld0_q),
    .rdata_o (bus.readdata)
  );

  // Valid is masked while the clock enable is low; the pending stage itself is kept.
  assign bus.readdatavalid = vld_out_s & clken;
  assign bus.waitrequest   = wait_s;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_soc_onchip_ram_burst.sv
// Directed bench driving an OUTREG=0 and an OUTREG=1 instance with identical stimulus.
module tb_soc_onchip_ram_burst;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b1;
  logic perr0, perr1;

  int n_cmp = 0;
  int n_mis = 0;
  int ecyc  = 0;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [127:0] mem_m [1024];

  soc_onchip_ram_burst_if #(.DATA_W(128), .ADDR_W(10), .BURST_W(4)) if0 ();
  soc_onchip_ram_burst_if #(.DATA_W(128), .ADDR_W(10), .BURST_W(4)) if1 ();

  assign if1.chipselect = if0.chipselect;
  assign if1.address    = if0.address;
  assign if1.burstcount = if0.burstcount;
  assign if1.byteenable = if0.byteenable;
  assign if1.read       = if0.read;
  assign if1.write      = if0.write;
  assign if1.writedata  = if0.writedata;

  soc_onchip_ram_burst #(.DATA_W(128), .DEPTH(1024), .ADDR_W(10), .BURST_W(4), .OUTREG(0)) dut0 (
    .clk(clk), .reset(reset), .clken(clken), .bus(if0), .protocol_err(perr0));
  soc_onchip_ram_burst #(.DATA_W(128), .DEPTH(1024), .ADDR_W(10), .BURST_W(4), .OUTREG(1)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .bus(if1), .protocol_err(perr1));

  always #5 clk = ~clk;

  // Enabled-edge counter used as the time base for expected valid beats.
  always @(posedge clk) begin
    if (clken) ecyc <= ecyc + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-instance monitor: every valid beat must match the queue head at its due cycle.
  task automatic mon(input string nm, input logic rdv, input logic [127:0] rdata, inout exp_t q[$]);
    exp_t e;
    if (!clken) begin
      check({nm, "_rdv_while_clken_low"}, 128'(rdv), 128'd0);
    end else if (rdv) begin
      if (q.size() == 0) begin
        check({nm, "_spurious_rdv"}, 128'(rdv), 128'd0);
      end else begin
        e = q.pop_front();
        check({nm, "_rdata"}, rdata, e.data);
        check({nm, "_rdv_cycle"}, 128'(ecyc), 128'(e.due));
      end
    end else if (q.size() > 0 && q[0].due <= ecyc) begin
      check({nm, "_missing_rdv"}, 128'(rdv), 128'd1);
      void'(q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon("d0", if0.readdatavalid, if0.readdata, q0);
      mon("d1", if1.readdatavalid, if1.readdata, q1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] nxt(input logic [9:0] a);
    return (a == 10'h3FF) ? 10'h000 : a + 10'h001;
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [127:0] d, input logic [15:0] be);
    for (int b = 0; b < 16; b++) begin
      if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic push_rd(input logic [9:0] a);
    q0.push_back('{mem_m[a], ecyc});
    q1.push_back('{mem_m[a], ecyc + 1});
  endtask

  task automatic bus_idle();
    if0.chipselect = 1'b0;
    if0.read       = 1'b0;
    if0.write      = 1'b0;
    if0.address    = 10'h000;
    if0.burstcount = 4'h1;
    if0.byteenable = 16'hFFFF;
    if0.writedata  = 128'h0;
  endtask

  // Called at a drive point (1 ns after a rising edge); returns at one.
  task automatic write_burst(input logic [9:0] a, input logic [3:0] bc, input logic [127:0] d0,
                             input logic [127:0] step, input logic [15:0] be);
    int n;
    logic [9:0] ad;
    n  = (bc == 4'h0) ? 1 : ((bc > 4'h8) ? 8 : int'(bc));
    ad = a;
    if0.chipselect = 1'b1;
    if0.write      = 1'b1;
    if0.read       = 1'b0;
    if0.address    = a;
    if0.burstcount = bc;
    if0.byteenable = be;
    for (int k = 0; k < n; k++) begin
      if0.writedata = d0 + 128'(k) * step;
      model_write(ad, if0.writedata, be);
      @(posedge clk); #1;
      ad = nxt(ad);
      if0.address    = 10'h155;
      if0.burstcount = 4'h0;
    end
    bus_idle();
  endtask

  task automatic read_burst(input logic [9:0] a, input int n, input int stall_at, input int stall_len);
    int wcnt;
    logic [9:0] ad;
    wcnt = 0;
    ad   = a;
    if0.chipselect = 1'b1;
    if0.read       = 1'b1;
    if0.address    = a;
    if0.burstcount = 4'(n);
    @(posedge clk); #1;
    push_rd(ad);
    bus_idle();
    for (int k = 1; k < n; k++) begin
      if (k == stall_at) begin
        clken = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
        end
        clken = 1'b1;
      end
      @(negedge clk);
      wcnt += int'(if0.waitrequest);
      @(posedge clk); #1;
      ad = nxt(ad);
      push_rd(ad);
    end
    @(negedge clk);
    wcnt += int'(if0.waitrequest);
    check("waitrequest_cycles", 128'(wcnt), 128'(n - 1));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check({tag, "_drain_d0"}, 128'(q0.size()), 128'd0);
    check({tag, "_drain_d1"}, 128'(q1.size()), 128'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    bus_idle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rdv0", 128'(if0.readdatavalid), 128'd0);
    check("rst_rdv1", 128'(if1.readdatavalid), 128'd0);
    check("rst_wait0", 128'(if0.waitrequest), 128'd0);
    check("rst_wait1", 128'(if1.waitrequest), 128'd0);
    check("rst_perr0", 128'(perr0), 128'd0);
    check("rst_perr1", 128'(perr1), 128'd0);
    check("rst_rdata0", if0.readdata, 128'd0);
    check("rst_rdata1", if1.readdata, 128'd0);
    @(posedge clk); #1;

    // Write burst then read burst of 4 at 0x010
    write_burst(10'h010, 4'h4, 128'hA0, 128'h1, 16'hFFFF);
    read_burst(10'h010, 4, -1, 0);
    drain("burst4");

    // Wrap-around at the top of memory
    write_burst(10'h3FE, 4'h4, 128'h1, 128'h1, 16'hFFFF);
    read_burst(10'h3FE, 1, -1, 0);
    read_burst(10'h3FF, 1, -1, 0);
    read_burst(10'h000, 1, -1, 0);
    read_burst(10'h001, 1, -1, 0);
    drain("wrap");

    // Byte enables
    write_burst(10'h005, 4'h1, {128{1'b1}}, 128'h0, 16'hFFFF);
    write_burst(10'h005, 4'h1, 128'h0, 128'h0, 16'h0001);
    check("be_model", mem_m[10'h005], {{120{1'b1}}, 8'h00});
    read_burst(10'h005, 1, -1, 0);
    drain("byteen");

    // Burst of 2 with clken low for 3 cycles between the beats
    read_burst(10'h010, 2, 1, 3);
    drain("clken");
    check("perr_clean", 128'(perr0), 128'd0);

    // Reset during the second beat of an 8-beat read burst
    write_burst(10'h020, 4'h8, 128'hC0, 128'h1, 16'hFFFF);
    if0.chipselect = 1'b1;
    if0.read       = 1'b1;
    if0.address    = 10'h020;
    if0.burstcount = 4'h8;
    @(posedge clk); #1;
    push_rd(10'h020);
    do_reset();
    @(negedge clk);
    check("post_rst_wait0", 128'(if0.waitrequest), 128'd0);
    check("post_rst_wait1", 128'(if1.waitrequest), 128'd0);
    check("post_rst_rdv0", 128'(if0.readdatavalid), 128'd0);
    check("post_rst_rdv1", 128'(if1.readdatavalid), 128'd0);
    @(posedge clk); #1;
    drain("midrst");
    read_burst(10'h020, 1, -1, 0);
    read_burst(10'h021, 1, -1, 0);
    drain("midrst_reread");

    // burstcount=0 acts as a single beat and flags an error
    write_burst(10'h101, 4'h1, 128'h99, 128'h0, 16'hFFFF);
    write_burst(10'h100, 4'h0, 128'h1234, 128'h1, 16'hFFFF);
    @(negedge clk);
    check("bc0_perr0", 128'(perr0), 128'd1);
    check("bc0_perr1", 128'(perr1), 128'd1);
    check("bc0_idle_wait", 128'(if0.waitrequest), 128'd0);
    @(posedge clk); #1;
    read_burst(10'h100, 1, -1, 0);
    read_burst(10'h101, 1, -1, 0);

    // read and write together: write wins, no data returned
    write_burst(10'h102, 4'h1, 128'h5555, 128'h0, 16'hFFFF);
    if0.chipselect = 1'b1;
    if0.read       = 1'b1;
    if0.write      = 1'b1;
    if0.address    = 10'h102;
    if0.burstcount = 4'h1;
    if0.writedata  = 128'h7777;
    model_write(10'h102, 128'h7777, 16'hFFFF);
    @(posedge clk); #1;
    bus_idle();
    drain("rdwr");
    read_burst(10'h102, 1, -1, 0);
    drain("rdwr_reread");
    check("rdwr_perr_sticky", 128'(perr0), 128'd1);

    // Error clears only on reset; oversize burst is clamped to 8 beats
    do_reset();
    @(negedge clk);
    check("perr_cleared", 128'(perr0), 128'd0);
    @(posedge clk); #1;
    write_burst(10'h208, 4'h1, 128'h77, 128'h0, 16'hFFFF);
    write_burst(10'h200, 4'hF, 128'h50, 128'h1, 16'hFFFF);
    @(negedge clk);
    check("clamp_perr", 128'(perr1), 128'd1);
    @(posedge clk); #1;
    read_burst(10'h207, 1, -1, 0);
    read_burst(10'h208, 1, -1, 0);
    drain("clamp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
